// File: rtl/lcd_feed_pkg.sv
// Shared constants for the LCD pixel feeder: coordinate widths and RGB565 colours.
// Also holds the colour-bar lookup used by the optional test pattern.
package lcd_feed_pkg;

  localparam int COORD_W = 11;
  localparam int SUM_W   = 12;
  localparam logic [COORD_W-1:0] COORD_MAX = 11'd2047;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RGB_WHITE   = 16'hFFFF;
  localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
  localparam rgb565_t RGB_CYAN    = 16'h07FF;
  localparam rgb565_t RGB_GREEN   = 16'h07E0;
  localparam rgb565_t RGB_MAGENTA = 16'hF81F;
  localparam rgb565_t RGB_RED     = 16'hF800;
  localparam rgb565_t RGB_BLUE    = 16'h001F;
  localparam rgb565_t RGB_BLACK   = 16'h0000;

  // Bar order runs left to right across the image window.
  function automatic rgb565_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_feed_fifo.sv
// Synchronous FIFO with flush, registered full flag and head-of-queue read.
// Empty comes from registered pointers, so a same-cycle push is not yet poppable.
module lcd_feed_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_nxt;
  logic [AW:0]       rd_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop_ok};
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// RGB565 pixel source for the LCD timing driver: FIFO-fed image centred on the panel.
// Define LCD_FEED_TESTPAT_EN to build the colour-bar test pattern selected by test_en.
module lcd_pixel_feeder
  import lcd_feed_pkg::*;
#(
  parameter int          IMG_W        = 320,
  parameter int          IMG_H        = 240,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BORDER_COLOR = 16'h0000,
  parameter logic [15:0] UNDER_COLOR  = 16'hF800
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  input  logic        out_vsync,
  input  logic        data_req,
  output logic [15:0] pixel_data,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  input  logic        test_en
);

  logic               vsync_p1;
  logic               req_p1;
  logic               ready_en;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [COORD_W-1:0] x_off;
  logic [COORD_W-1:0] y_off;
  logic [SUM_W-1:0]   x_end;
  logic [SUM_W-1:0]   y_end;
  logic               in_win;
  logic               test_act;
  logic               fifo_flush;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [15:0]        fifo_head;
  logic               under_set;
  logic [15:0]        pix_p0;

  function automatic logic [COORD_W-1:0] center_off(input logic [COORD_W-1:0] disp,
                                                    input int img);
    logic [SUM_W-1:0] d;
    logic [SUM_W-1:0] i;
    logic [SUM_W-1:0] diff;
    d    = {1'b0, disp};
    i    = 12'(img);
    diff = d - i;
    return (d > i) ? diff[SUM_W-1:1] : '0;
  endfunction

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 11'd1;
  endfunction

`ifdef LCD_FEED_TESTPAT_EN
  localparam int BAR_W = IMG_W / 8;

  logic [COORD_W-1:0] x_rel;
  logic [2:0]         bar_idx;

  assign test_act = test_en;
  assign x_rel    = x_cnt - x_off;

  // Last bar takes whatever IMG_W/8 leaves over.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, x_rel} >= 12'(k * BAR_W)) bar_idx = 3'(k);
    end
  end
`else
  logic unused_test_en;

  assign test_act       = 1'b0;
  assign unused_test_en = test_en;
`endif

  assign x_end  = {1'b0, x_off} + 12'(IMG_W);
  assign y_end  = {1'b0, y_off} + 12'(IMG_H);
  assign in_win = ({1'b0, x_cnt} >= {1'b0, x_off}) && ({1'b0, x_cnt} < x_end) &&
                  ({1'b0, y_cnt} >= {1'b0, y_off}) && ({1'b0, y_cnt} < y_end);

  assign fifo_flush = frame_start || test_act;
  assign s_ready    = ready_en && !fifo_full && !frame_start && !test_act;
  assign fifo_push  = s_valid && s_ready;
  assign fifo_pop   = data_req && in_win && !fifo_empty && !test_act;
  assign under_set  = data_req && in_win && fifo_empty && !test_act;

  lcd_feed_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (16)
  ) u_fifo (
    .lcd_pclk (lcd_pclk),
    .rst_n    (rst_n),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (s_data),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Stage p0: pixel choice for the request presented this cycle
  always_comb begin
    pix_p0 = '0;
    if (data_req) begin
      if (!in_win)         pix_p0 = BORDER_COLOR;
`ifdef LCD_FEED_TESTPAT_EN
      else if (test_act)   pix_p0 = bar_color(bar_idx);
`endif
      else if (fifo_empty) pix_p0 = UNDER_COLOR;
      else                 pix_p0 = fifo_head;
    end
  end

  // Stage p1: registered pixel, frame control and counters
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1    <= 1'b0;
      req_p1      <= 1'b0;
      ready_en    <= 1'b0;
      frame_start <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      x_off       <= '0;
      y_off       <= '0;
      underflow   <= 1'b0;
      pixel_data  <= '0;
    end else begin
      vsync_p1    <= out_vsync;
      req_p1      <= data_req;
      ready_en    <= 1'b1;
      frame_start <= out_vsync && !vsync_p1;
      pixel_data  <= pix_p0;

      if (frame_start) begin
        x_cnt <= '0;
        y_cnt <= '0;
        x_off <= center_off(h_disp, IMG_W);
        y_off <= center_off(v_disp, IMG_H);
      end else if (data_req) begin
        x_cnt <= sat_inc(x_cnt);
      end else if (req_p1) begin
        x_cnt <= '0;
        y_cnt <= sat_inc(y_cnt);
      end

      if (under_set)          underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Directed bench for lcd_pixel_feeder on a 480x272 panel with a 320x240 window.
// Colour-bar checks are compiled in when LCD_FEED_TESTPAT_EN is defined.
module tb_lcd_pixel_feeder;

  localparam logic [15:0] BORDER = 16'h4208;
  localparam logic [15:0] UNDER  = 16'hF800;

  logic        lcd_pclk = 1'b0;
  logic        rst_n;
  logic [10:0] h_disp = 11'd480;
  logic [10:0] v_disp = 11'd272;
  logic        out_vsync;
  logic        data_req;
  logic [15:0] pixel_data;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        frame_start;
  logic        underflow;
  logic        underflow_clr;
  logic        test_en;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] new_base;
  logic [15:0] fbase;
  logic [15:0] pv;
  logic [15:0] exp_pix;

  lcd_pixel_feeder #(
    .IMG_W        (320),
    .IMG_H        (240),
    .FIFO_DEPTH   (16),
    .BORDER_COLOR (BORDER),
    .UNDER_COLOR  (UNDER)
  ) dut (
    .lcd_pclk      (lcd_pclk),
    .rst_n         (rst_n),
    .h_disp        (h_disp),
    .v_disp        (v_disp),
    .out_vsync     (out_vsync),
    .data_req      (data_req),
    .pixel_data    (pixel_data),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .test_en       (test_en)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the upstream source advances its data on every accepted handshake.
  task automatic tick();
    logic hs;
    @(negedge lcd_pclk);
    hs = s_valid && s_ready;
    @(posedge lcd_pclk);
    #1;
    if (hs) s_data = s_data + 16'd1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      data_req = 1'b1;
      tick();
      data_req = 1'b0;
      tick();
    end
  endtask

  task automatic reqs(input int n);
    data_req = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; out_vsync = 1'b0; data_req = 1'b0; s_valid = 1'b0;
    s_data = 16'd0; underflow_clr = 1'b0; test_en = 1'b0;
    repeat (3) @(posedge lcd_pclk);
    #1;
    chk("rst_pix", pixel_data, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_uf", underflow, 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_pix", pixel_data, 0);
    chk("idle_fs", frame_start, 0);
    chk("idle_uf", underflow, 0);

    // Frame start pulse, one cycle after the vsync edge
    out_vsync = 1'b1;
    tick();
    chk("fs_rise", frame_start, 1);
    chk("ready_flush", s_ready, 0);
    tick();
    chk("fs_once", frame_start, 0);
    chk("ready_back", s_ready, 1);
    out_vsync = 1'b0;

    // Prefill while stepping down to line 20
    s_valid = 1'b1;
    for (int l = 0; l < 20; l++) begin
      data_req = 1'b1;
      tick();
      chk("short_border", pixel_data, BORDER);
      data_req = 1'b0;
      tick();
    end
    chk("req_low_zero", pixel_data, 0);
    chk("prefill_full", s_ready, 0);

    for (int i = 0; i < 480; i++) begin
      data_req = 1'b1;
      tick();
      if (i >= 80 && i < 400) exp_pix = 16'(i - 80);
      else                    exp_pix = BORDER;
      chk("line20", pixel_data, exp_pix);
    end
    data_req = 1'b0;
    tick();
    chk("l20_end_zero", pixel_data, 0);
    chk("l20_no_uf", underflow, 0);

    // Line 5 above the window with a full FIFO
    out_vsync = 1'b1;
    tick();
    chk("fs_l5", frame_start, 1);
    new_base  = s_data;
    out_vsync = 1'b0;
    tick();
    short_lines(5);
    idle(10);
    chk("full_l5", s_ready, 0);
    for (int i = 0; i < 480; i++) begin
      data_req = 1'b1;
      tick();
      chk("l5_border", pixel_data, BORDER);
    end
    chk("l5_no_pop", s_ready, 0);
    data_req = 1'b0;
    tick();

    // Drain on line 16 with no upstream data, then underflow
    s_valid = 1'b0;
    short_lines(10);
    for (int i = 0; i <= 96; i++) begin
      data_req = 1'b1;
      tick();
      if (i == 79) chk("l16_border", pixel_data, BORDER);
      if (i >= 80 && i < 96) chk("head_order", pixel_data, new_base + 16'(i - 80));
      if (i == 95) chk("uf_not_yet", underflow, 0);
      if (i == 96) begin
        chk("under_pix", pixel_data, UNDER);
        chk("uf_set", underflow, 1);
      end
    end
    data_req = 1'b0;
    tick();
    chk("uf_sticky", underflow, 1);
    chk("uf_line_zero", pixel_data, 0);
    underflow_clr = 1'b1;
    tick();
    chk("uf_clr", underflow, 0);
    underflow_clr = 1'b0;

    reqs(80);
    underflow_clr = 1'b1;
    s_valid       = 1'b1;
    pv            = s_data;
    tick();
    chk("under_same_push", pixel_data, UNDER);
    chk("uf_set_wins", underflow, 1);
    underflow_clr = 1'b0;
    s_valid       = 1'b0;
    tick();
    chk("push_next", pixel_data, pv);
    data_req = 1'b0;
    tick();

    // Frame restart in the middle of an in-window line with a full FIFO
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("g_uf_clr", underflow, 0);
    s_valid = 1'b1;
    idle(20);
    chk("g_full", s_ready, 0);
    reqs(10);
    out_vsync = 1'b1;
    tick();
    chk("g_fs", frame_start, 1);
    chk("g_ready_flush", s_ready, 0);
    fbase     = s_data;
    out_vsync = 1'b0;
    tick();
    chk("g_ready_back", s_ready, 1);
    for (int j = 1; j <= 101; j++) begin
      tick();
      if (j >= 81) chk("y_restart", pixel_data, BORDER);
    end
    data_req = 1'b0;
    tick();
    short_lines(15);
    reqs(80);
    tick();
    chk("new_stream", pixel_data, fbase);
    data_req = 1'b0;
    tick();

`ifdef LCD_FEED_TESTPAT_EN
    test_en       = 1'b1;
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    short_lines(3);
    for (int i = 0; i < 400; i++) begin
      data_req = 1'b1;
      tick();
      case (i)
        79:  chk("tp_border", pixel_data, BORDER);
        80:  chk("tp_x80", pixel_data, 16'hFFFF);
        119: chk("tp_x119", pixel_data, 16'hFFFF);
        120: chk("tp_x120", pixel_data, 16'hFFE0);
        200: chk("tp_ready_mid", s_ready, 0);
        319: chk("tp_x319", pixel_data, 16'hF800);
        399: chk("tp_x399", pixel_data, 16'h0000);
        default: ;
      endcase
    end
    data_req = 1'b0;
    tick();
    chk("tp_ready", s_ready, 0);
    chk("tp_uf", underflow, 0);
    test_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
